hex_str_streamer: RTL and testbench

Byte-serializer that sits directly downstream of `binary2hex`. It accepts one packed ASCII hex string per transaction through a valid/ready handshake and emits it one character per beat on a byte-wide valid/ready stream, most-significant character first. Optional leading-zero suppression and CR/LF termination make the output line-ready for a UART/console TX stage.

---
 rtl/hex_str_streamer.sv | 216 +++++++++++++++++++++
 tb/tb_hex_str_streamer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_str_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : hex_str_streamer
//  Description : Serializes a packed ASCII hex string (as produced by
//                binary2hex) into a byte-wide valid/ready stream, MSB
//                character first. Optional leading-zero suppression and
//                CR/LF line termination for a UART/console TX stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_str_streamer #(
    parameter int N           = 32,
    parameter int LZ_SUPPRESS = 0,
    parameter int APPEND_CRLF = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [(N/4)*8-1:0]   hex_str,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_char,
    output logic                 out_last,
    output logic                 busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_chars = N / 4;                 // characters per string
    localparam int c_w     = c_chars * 8;           // string width in bits
    localparam int c_cw    = $clog2(c_chars + 1);   // char counter width

    localparam logic [c_cw-1:0] c_cnt_full = c_cw'(c_chars);
    localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
    localparam logic [c_cw-1:0] c_cnt_two  = c_cw'(2);

    localparam logic [7:0] c_ascii_zero = 8'h30;
    localparam logic [7:0] c_ascii_cr   = 8'h0D;
    localparam logic [7:0] c_ascii_lf   = 8'h0A;

    // Controller states: IDLE waits for a string, SKIP drops leading zeros,
    // SEND streams hex characters, CR/LF append the line terminator.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SKIP = 3'd1,
        S_SEND = 3'd2,
        S_CR   = 3'd3,
        S_LF   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [c_w-1:0]      r_shift;      // remaining characters, next one on top
    logic [c_cw-1:0]     r_count;      // characters still held in r_shift
    logic                r_in_ready;
    logic                r_out_valid;
    logic [7:0]          r_out_char;
    logic                r_out_last;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                w_lz_en;
    logic                w_crlf_en;
    logic                w_accept;
    logic                w_beat;
    logic                w_last_char;
    logic                w_single_last;
    logic [7:0]          w_top;
    logic [7:0]          w_in_top;
    logic [c_w-1:0]      w_shifted;
    logic [7:0]          w_next_top;
    logic [c_cw-1:0]     w_count_dec;

    assign w_lz_en       = (LZ_SUPPRESS != 0);
    assign w_crlf_en     = (APPEND_CRLF != 0);

    // A string is taken only while the block advertises ready (IDLE).
    assign w_accept      = in_valid && r_in_ready;

    // A beat is a completed output handshake on the byte stream.
    assign w_beat        = r_out_valid && out_ready;

    assign w_last_char   = (r_count == c_cnt_one);

    // A one-character string is final on entry unless CR/LF follow it.
    assign w_single_last = (c_chars == 1) && !w_crlf_en;

    // Current and upcoming characters. Shifting left by a byte brings the
    // next character to the top; for a one-char string this yields zero,
    // which is never used because the last character ends the string.
    assign w_top         = r_shift[c_w-1 -: 8];
    assign w_in_top      = hex_str[c_w-1 -: 8];
    assign w_shifted     = r_shift << 8;
    assign w_next_top    = w_shifted[c_w-1 -: 8];
    assign w_count_dec   = r_count - c_cnt_one;

    // ------------------------------------------------------------------------
    // Outputs: all stream outputs come straight from flops; busy decodes the
    // state register only.
    // ------------------------------------------------------------------------
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_char  = r_out_char;
    assign out_last  = r_out_last;
    assign busy      = (r_state != S_IDLE);

    // Controller: state, shift register, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_char  <= 8'h00;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                // Wait for a string. Ready is raised one cycle after reset
                // release and dropped on the accepting edge.
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift    <= hex_str;
                        r_count    <= c_cnt_full;
                        r_in_ready <= 1'b0;
                        if (w_lz_en) begin
                            r_state <= S_SKIP;
                        end else begin
                            // Present the first character right away so
                            // out_valid rises the cycle after the accept.
                            r_state     <= S_SEND;
                            r_out_valid <= 1'b1;
                            r_out_char  <= w_in_top;
                            r_out_last  <= w_single_last;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end

                // Drop one leading '0' per cycle, always keeping the final
                // character so an all-zero string still prints "0".
                S_SKIP: begin
                    if ((w_top == c_ascii_zero) && (r_count > c_cnt_one)) begin
                        r_shift <= w_shifted;
                        r_count <= w_count_dec;
                    end else begin
                        r_state     <= S_SEND;
                        r_out_valid <= 1'b1;
                        r_out_char  <= w_top;
                        r_out_last  <= w_last_char && !w_crlf_en;
                    end
                end

                // Stream characters; outputs hold steady until a beat.
                S_SEND: begin
                    if (w_beat) begin
                        if (w_last_char) begin
                            if (w_crlf_en) begin
                                r_state    <= S_CR;
                                r_out_char <= c_ascii_cr;
                                r_out_last <= 1'b0;
                            end else begin
                                r_state     <= S_IDLE;
                                r_out_valid <= 1'b0;
                                r_out_char  <= 8'h00;
                                r_out_last  <= 1'b0;
                                r_in_ready  <= 1'b1;
                            end
                        end else begin
                            r_shift    <= w_shifted;
                            r_count    <= w_count_dec;
                            r_out_char <= w_next_top;
                            // The character after this beat is the final one
                            // when exactly two remain now.
                            r_out_last <= (r_count == c_cnt_two) && !w_crlf_en;
                        end
                    end
                end

                // Carriage return, then line feed which closes the string.
                S_CR: begin
                    if (w_beat) begin
                        r_state    <= S_LF;
                        r_out_char <= c_ascii_lf;
                        r_out_last <= 1'b1;
                    end
                end

                S_LF: begin
                    if (w_beat) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_out_char  <= 8'h00;
                        r_out_last  <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_out_char  <= 8'h00;
                    r_out_last  <= 1'b0;
                    r_in_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_str_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_str_streamer
//  Description : Self-checking bench for hex_str_streamer. Four instances
//                cover every LZ_SUPPRESS / APPEND_CRLF combination; the
//                expected byte streams come from a string-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_str_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  iv;
    logic [63:0] hs;
    logic        ordy;
    logic [3:0]  ir;
    logic [3:0]  ov;
    logic [3:0]  ol;
    logic [3:0]  bz;
    logic [7:0]  oc [4];

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    // Instance g: LZ_SUPPRESS = g%2, APPEND_CRLF = g/2.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        hex_str_streamer #(
            .N           (32),
            .LZ_SUPPRESS (g % 2),
            .APPEND_CRLF (g / 2)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .hex_str   (hs),
            .out_valid (ov[g]),
            .out_ready (ordy),
            .out_char  (oc[g]),
            .out_last  (ol[g]),
            .busy      (bz[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: the byte sequence a console should receive for a string.
    task automatic model(input logic [63:0] s, input int lz, input int crlf, output int k);
        logic [7:0] c [8];
        for (int i = 0; i < 8; i++) c[i] = s[63-8*i -: 8];
        k = 0;
        if (lz != 0) while (k < 7 && c[k] == 8'h30) k++;
        exp_q.delete();
        for (int i = k; i < 8; i++) exp_q.push_back(c[i]);
        if (crlf != 0) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    function automatic logic [63:0] rnd_str();
        logic [63:0] s;
        int nz;
        s  = '0;
        nz = $urandom_range(0, 8);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] c;
            int v;
            v = $urandom_range(0, 16);
            if (i < nz)       c = 8'h30;
            else if (v == 16) c = 8'($urandom_range(0, 255));
            else if (v < 10)  c = 8'(48 + v);
            else              c = 8'(55 + v);
            s[63-8*i -: 8] = c;
        end
        return s;
    endfunction

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic start(input int idx, input logic [63:0] s);
        int w;
        w = 0;
        while (ir[idx] !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", 32'(w < 20), 32'd1);
        hs      = s;
        iv[idx] = 1'b1;
        @(negedge clk);
        iv[idx] = 1'b0;
    endtask

    // mode 0: out_ready high, 1: toggling, 2: random.
    // exp_lat: sample index (0 = first cycle after accept) of first out_valid.
    task automatic collect(input int idx, input int mode, input int exp_lat, input string tag);
        int first, lastbeat, stab, irhi;
        bit done, pv, pb, pl, beat;
        logic [7:0] pc;
        got_q.delete();
        first = -1; lastbeat = 0; stab = 0; irhi = 0;
        done = 0; pv = 0; pb = 0; pl = 0; pc = 8'h00;
        for (int i = 0; i < 80 && !done; i++) begin
            case (mode)
                0:       ordy = 1'b1;
                1:       ordy = (i % 2 == 0);
                default: ordy = 1'($urandom_range(0, 1));
            endcase
            if (pv && !pb && (ov[idx] !== 1'b1 || oc[idx] !== pc || ol[idx] !== pl)) stab++;
            if (ir[idx] === 1'b1) irhi++;
            if (ov[idx] === 1'b1 && first < 0) first = i;
            beat = (ov[idx] === 1'b1) && ordy;
            if (beat) begin
                got_q.push_back(oc[idx]);
                if (ol[idx] === 1'b1) begin
                    done     = 1;
                    lastbeat = i;
                end
            end
            pv = (ov[idx] === 1'b1); pb = beat; pc = oc[idx]; pl = (ol[idx] === 1'b1);
            @(negedge clk);
        end
        chk({tag, "_last_seen"}, 32'(done), 32'd1);
        chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size(); j++)
            chk({tag, "_byte"}, (j < got_q.size()) ? 32'(got_q[j]) : 32'hFFFF_FFFF, 32'(exp_q[j]));
        chk({tag, "_stable"}, 32'(stab), 32'd0);
        chk({tag, "_ready_low"}, 32'(irhi), 32'd0);
        chk({tag, "_latency"}, 32'(first), 32'(exp_lat));
        if (mode == 0) chk({tag, "_consecutive"}, 32'(lastbeat - first), 32'(exp_q.size() - 1));
        chk({tag, "_idle_ready"}, 32'(ir[idx]), 32'd1);
        chk({tag, "_idle_busy"},  32'(bz[idx]), 32'd0);
        chk({tag, "_idle_valid"}, 32'(ov[idx]), 32'd0);
    endtask

    task automatic run(input int idx, input logic [63:0] s, input int mode, input string tag);
        int k;
        model(s, idx % 2, idx / 2, k);
        start(idx, s);
        collect(idx, mode, (idx % 2 != 0) ? k + 1 : 0, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; iv = 4'h0; hs = '0; ordy = 1'b0;

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(ir), 32'h0);
        chk("rst_out_valid", 32'(ov), 32'h0);
        chk("rst_out_last", 32'(ol), 32'h0);
        chk("rst_busy", 32'(bz), 32'h0);
        chk("rst_out_char", 32'(oc[0]), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(ir), 32'hF);

        // Plain streaming, leading-zero suppression, CR/LF, backpressure.
        run(0, "CAF01357", 0, "plain");
        run(1, "0000001F", 0, "lz_1f");
        run(1, "00000000", 0, "lz_zero");
        run(1, "FFFFFFFF", 0, "lz_ff");
        run(2, "AAAAAAAA", 0, "crlf");
        run(0, "CAF01357", 1, "bp");
        run(3, "00000000", 1, "lz_crlf_zero");

        // Second string offered during the first must wait for IDLE.
        model("CAF01357", 0, 0, k);
        start(0, "CAF01357");
        iv[0] = 1'b1;
        hs    = "12345678";
        collect(0, 0, 0, "held_a");
        @(negedge clk);
        iv[0] = 1'b0;
        model("12345678", 0, 0, k);
        collect(0, 0, 0, "held_b");

        // Randomized strings and backpressure on the non-default variants.
        for (int t = 0; t < 12; t++) run(1 + t % 3, rnd_str(), 2, "rnd");

        // Asynchronous reset after the third beat.
        model("CAF01357", 0, 0, k);
        start(0, "CAF01357");
        ordy = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ov[0]), 32'd0);
        chk("arst_busy", 32'(bz[0]), 32'd0);
        chk("arst_last", 32'(ol[0]), 32'd0);
        chk("arst_char", 32'(oc[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_ready", 32'(ir[0]), 32'd1);
        run(0, "00000000", 0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
